// File: rtl/pong_vga_pkg.sv
// Shared VGA 640x480@60 timing constants, colour codes and game-state snapshot
// type for the PONG renderer.
package pong_vga_pkg;

  localparam logic [9:0] H_VISIBLE    = 10'd640;
  localparam logic [9:0] H_FRONT      = 10'd16;
  localparam logic [9:0] H_SYNC       = 10'd96;
  localparam logic [9:0] H_BACK       = 10'd48;
  localparam logic [9:0] H_TOTAL      = 10'd800;
  localparam logic [9:0] H_LAST       = H_TOTAL - 10'd1;
  localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;

  localparam logic [9:0] V_VISIBLE    = 10'd480;
  localparam logic [9:0] V_FRONT      = 10'd10;
  localparam logic [9:0] V_SYNC       = 10'd2;
  localparam logic [9:0] V_BACK       = 10'd33;
  localparam logic [9:0] V_TOTAL      = 10'd525;
  localparam logic [9:0] V_LAST       = V_TOTAL - 10'd1;
  localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam logic [4:0] SCORE_MAX = 5'd15;

  // Colours packed as {R,G,B}, 4 bits each.
  localparam logic [11:0] COLOR_BLACK  = 12'h000;
  localparam logic [11:0] COLOR_WHITE  = 12'hFFF;
  localparam logic [11:0] COLOR_PLAT1  = 12'h0F0;
  localparam logic [11:0] COLOR_PLAT2  = 12'h00F;
  localparam logic [11:0] COLOR_SCORE  = 12'hFF0;
  localparam logic [11:0] COLOR_CENTRE = 12'h888;
  localparam logic [11:0] COLOR_WIN1   = 12'h040;
  localparam logic [11:0] COLOR_WIN2   = 12'h004;

  typedef struct packed {
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [9:0] plat1_x;
    logic [9:0] plat1_y;
    logic [9:0] plat1_h;
    logic [9:0] plat2_x;
    logic [9:0] plat2_y;
    logic [9:0] plat2_h;
    logic [3:0] score1;
    logic [3:0] score2;
    logic       win1;
    logic       win2;
  } game_state_t;

  function automatic logic [3:0] clamp_score(input logic [4:0] s);
    return (s > SCORE_MAX) ? SCORE_MAX[3:0] : s[3:0];
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-rate divider and 800x525 raster counters; registers the counter view
// (h, v, de, hs, vs) one tick behind the free-running counters.
module vga_timing
  import pong_vga_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic       pix_en,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       de,
  output logic       hs,
  output logic       vs,
  output logic       frame_start
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic             h_wrap;
  logic             v_wrap;

  // Gating with RESET keeps ticks (and frame_start) silent while held in reset.
  assign pix_en      = RESET && (div_cnt == DIV_LAST);
  assign h_wrap      = (h_cnt == H_LAST);
  assign v_wrap      = (v_cnt == V_LAST);
  assign frame_start = pix_en && (h_cnt == '0) && (v_cnt == '0);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
      h       <= '0;
      v       <= '0;
      de      <= 1'b0;
      hs      <= 1'b1;
      vs      <= 1'b1;
    end else begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      if (pix_en) begin
        h_cnt <= h_wrap ? '0 : h_cnt + 10'd1;
        if (h_wrap) begin
          v_cnt <= v_wrap ? '0 : v_cnt + 10'd1;
        end
        h  <= h_cnt;
        v  <= v_cnt;
        de <= (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE);
        hs <= !((h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END));
        vs <= !((v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END));
      end
    end
  end

endmodule

// File: rtl/pong_vga_renderer.sv
// PONG renderer: snapshots game state at vblank, draws ball, platforms, score
// bars, centre line and win flash into a registered 4-bit RGB VGA stream.
module pong_vga_renderer
  import pong_vga_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int BALL_R    = 5,
  parameter int PLAT_W    = 5,
  parameter int FLASH_BIT = 5
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [9:0] ballX,
  input  logic [9:0] ballY,
  input  logic [9:0] plat1X,
  input  logic [9:0] plat1Y,
  input  logic [9:0] plat1H,
  input  logic [9:0] plat2X,
  input  logic [9:0] plat2Y,
  input  logic [9:0] plat2H,
  input  logic [4:0] Score_1,
  input  logic [4:0] Score_2,
  input  logic       WIN1,
  input  logic       WIN2,
  output logic [3:0] VGA_R,
  output logic [3:0] VGA_G,
  output logic [3:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       frame_start
);

  localparam logic [10:0] BALL_R_W = 11'(BALL_R);
  localparam logic [10:0] PLAT_W_W = 11'(PLAT_W);

  logic        pix_en;
  logic [9:0]  h;
  logic [9:0]  v;
  logic        de;
  logic        hs;
  logic        vs;

  game_state_t snap;
  logic        snap_valid;
  logic [7:0]  frame_cnt;
  logic [11:0] rgb;
  logic [11:0] pix_color;

  logic [10:0] px, py;
  logic [10:0] d_left, d_right;
  logic        ball_hit, plat1_hit, plat2_hit, score_hit, centre_hit;
  logic        score_row, left_hit, right_hit, flash_on;

  vga_timing #(.CLK_DIV(CLK_DIV)) u_timing (
    .CLK         (CLK),
    .RESET       (RESET),
    .pix_en      (pix_en),
    .h           (h),
    .v           (v),
    .de          (de),
    .hs          (hs),
    .vs          (vs),
    .frame_start (frame_start)
  );

  // Snapshot and frame counter follow the registered raster view so that the
  // whole visible frame renders from one consistent state.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      snap       <= '0;
      snap_valid <= 1'b0;
      frame_cnt  <= '0;
    end else if (pix_en) begin
      if ((h == '0) && (v == V_VISIBLE)) begin
        snap.ball_x  <= ballX;
        snap.ball_y  <= ballY;
        snap.plat1_x <= plat1X;
        snap.plat1_y <= plat1Y;
        snap.plat1_h <= plat1H;
        snap.plat2_x <= plat2X;
        snap.plat2_y <= plat2Y;
        snap.plat2_h <= plat2H;
        snap.score1  <= clamp_score(Score_1);
        snap.score2  <= clamp_score(Score_2);
        snap.win1    <= WIN1;
        snap.win2    <= WIN2;
        snap_valid   <= 1'b1;
      end
      if ((h == H_LAST) && (v == V_LAST)) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  assign px = {1'b0, h};
  assign py = {1'b0, v};

  // All compares are add-only or guarded so that nothing can underflow.
  assign ball_hit = (px + BALL_R_W >= {1'b0, snap.ball_x}) && (px < {1'b0, snap.ball_x} + BALL_R_W) &&
                    (py + BALL_R_W >= {1'b0, snap.ball_y}) && (py < {1'b0, snap.ball_y} + BALL_R_W);

  assign plat1_hit = (px >= {1'b0, snap.plat1_x}) && (px < {1'b0, snap.plat1_x} + PLAT_W_W) &&
                     (py >= {1'b0, snap.plat1_y}) && (py <= {1'b0, snap.plat1_y} + {1'b0, snap.plat1_h});

  assign plat2_hit = (px >= {1'b0, snap.plat2_x}) && (px < {1'b0, snap.plat2_x} + PLAT_W_W) &&
                     (py >= {1'b0, snap.plat2_y}) && (py <= {1'b0, snap.plat2_y} + {1'b0, snap.plat2_h});

  assign score_row  = (py >= 11'd4) && (py < 11'd12);
  assign d_left     = px - 11'd32;
  assign d_right    = 11'd607 - px;
  assign left_hit   = (px >= 11'd32) && (d_left < 11'({snap.score2, 4'b0000})) && (d_left[3:0] < 4'd12);
  assign right_hit  = (px <= 11'd607) && (d_right < 11'({snap.score1, 4'b0000})) && (d_right[3:0] < 4'd12);
  assign score_hit  = score_row && (left_hit || right_hit);
  assign centre_hit = ((px == 11'd319) || (px == 11'd320)) && !py[3];
  assign flash_on   = frame_cnt[FLASH_BIT];

  always_comb begin
    pix_color = COLOR_BLACK;
    if (!de || !snap_valid) begin
      pix_color = COLOR_BLACK;
    end else if (ball_hit) begin
      pix_color = COLOR_WHITE;
    end else if (plat1_hit) begin
      pix_color = COLOR_PLAT1;
    end else if (plat2_hit) begin
      pix_color = COLOR_PLAT2;
    end else if (score_hit) begin
      pix_color = COLOR_SCORE;
    end else if (centre_hit) begin
      pix_color = COLOR_CENTRE;
    end else if (snap.win1 && flash_on) begin
      pix_color = COLOR_WIN1;
    end else if (snap.win2 && flash_on) begin
      pix_color = COLOR_WIN2;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      rgb    <= COLOR_BLACK;
      VGA_HS <= 1'b1;
      VGA_VS <= 1'b1;
    end else if (pix_en) begin
      rgb    <= pix_color;
      VGA_HS <= hs;
      VGA_VS <= vs;
    end
  end

  assign VGA_R = rgb[11:8];
  assign VGA_G = rgb[7:4];
  assign VGA_B = rgb[3:0];

endmodule

// File: tb/tb_pong_vga_renderer.sv
// Directed bench for pong_vga_renderer: sync timing, snapshot gating, pixel
// rules, win flash and mid-line reset, with hand-computed expected values.
module tb_pong_vga_renderer;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic [9:0] ballX, ballY, plat1X, plat1Y, plat1H, plat2X, plat2Y, plat2H;
  logic [4:0] Score_1, Score_2;
  logic       WIN1, WIN2;
  logic [3:0] VGA_R, VGA_G, VGA_B;
  logic       VGA_HS, VGA_VS, frame_start;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int clk_since = 0;
  int frame_no = -1;
  int last_fs = -1;
  int fs_period = 0;

  pong_vga_renderer #(.CLK_DIV(2), .BALL_R(5), .PLAT_W(5), .FLASH_BIT(0)) dut (
    .CLK(CLK), .RESET(RESET),
    .ballX(ballX), .ballY(ballY),
    .plat1X(plat1X), .plat1Y(plat1Y), .plat1H(plat1H),
    .plat2X(plat2X), .plat2Y(plat2Y), .plat2H(plat2H),
    .Score_1(Score_1), .Score_2(Score_2),
    .WIN1(WIN1), .WIN2(WIN2),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .frame_start(frame_start)
  );

  always #5 CLK = ~CLK;

  // Pins show pixel (clk_since/2 - 1) of the current frame (2 CLK per tick, 2-tick lag).
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (frame_start) begin
      clk_since <= 0;
      frame_no  <= frame_no + 1;
      if (last_fs >= 0) fs_period <= cyc - last_fs;
      last_fs <= cyc;
    end else begin
      clk_since <= clk_since + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic wait_pixel(input int x, input int y);
    int target;
    int budget;
    target = y * 800 + x;
    budget = 900000;
    do begin
      @(negedge CLK);
      budget--;
    end while ((clk_since / 2 - 1 != target) && (budget > 0));
    if (budget == 0) check_val($sformatf("wait_pix_%0d_%0d", x, y), 32'(budget), 32'd1);
  endtask

  task automatic check_pix(input int x, input int y, input logic [11:0] exp);
    wait_pixel(x, y);
    check_val($sformatf("pix_f%0d_%0d_%0d", frame_no, x, y), 32'({VGA_R, VGA_G, VGA_B}), 32'(exp));
  endtask

  task automatic wait_frame(input int n);
    int budget;
    budget = 900000;
    while ((frame_no != n) && (budget > 0)) begin
      @(negedge CLK);
      budget--;
    end
    if (budget == 0) check_val($sformatf("wait_frame_%0d", n), 32'(budget), 32'd1);
  endtask

  task automatic wait_level(input string tag, input logic want_hs, input logic lvl, output int n);
    n = 0;
    while ((((want_hs ? VGA_HS : VGA_VS)) != lvl) && (n < 900000)) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 900000) check_val({tag, "_timeout"}, 32'(n), 32'd0);
  endtask

  initial begin
    int n;
    ballX = 10'd320; ballY = 10'd240;
    plat1X = 10'd620; plat1Y = 10'd220; plat1H = 10'd40;
    plat2X = 10'd10;  plat2Y = 10'd100; plat2H = 10'd50;
    Score_1 = 5'd20; Score_2 = 5'd3;
    WIN1 = 1'b0; WIN2 = 1'b0;

    repeat (3) @(negedge CLK);
    check_val("rst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'h000);
    check_val("rst_hs", 32'(VGA_HS), 32'd1);
    check_val("rst_vs", 32'(VGA_VS), 32'd1);
    check_val("rst_fs", 32'(frame_start), 32'd0);

    RESET = 1'b1;
    #1 check_val("fs_cycle1", 32'(frame_start), 32'd0);
    @(negedge CLK);
    check_val("fs_cycle2", 32'(frame_start), 32'd1);

    // Frame 0: sync shape and alignment, no snapshot yet.
    wait_level("hs_fall", 1'b1, 1'b0, n);
    check_val("hs_fall_pos", 32'(clk_since), 32'd1314);
    wait_level("hs_rise", 1'b1, 1'b1, n);
    check_val("hs_low_clk", 32'(n), 32'd192);
    wait_level("hs_fall2", 1'b1, 1'b0, n);
    check_val("hs_high_clk", 32'(n), 32'd1408);
    check_pix(40, 5, 12'h000);
    check_pix(315, 235, 12'h000);
    wait_level("vs_fall", 1'b0, 1'b0, n);
    check_val("vs_fall_pos", 32'(clk_since), 32'd784002);
    wait_level("vs_rise", 1'b0, 1'b1, n);
    check_val("vs_low_clk", 32'(n), 32'd3200);

    // Frame 1: first snapshot.
    wait_frame(1);
    check_val("frame_period", 32'(fs_period), 32'd840000);
    check_pix(319, 0, 12'h888);
    check_pix(32, 5, 12'hFF0);
    check_pix(43, 5, 12'hFF0);
    check_pix(44, 5, 12'h000);
    check_pix(75, 5, 12'hFF0);
    check_pix(76, 5, 12'h000);
    check_pix(79, 5, 12'h000);
    check_pix(80, 5, 12'h000);
    check_pix(367, 5, 12'h000);
    check_pix(372, 5, 12'hFF0);
    check_pix(607, 5, 12'hFF0);
    check_pix(608, 5, 12'h000);
    check_pix(320, 8, 12'h000);
    check_pix(320, 16, 12'h888);
    check_pix(10, 100, 12'h00F);
    ballX = 10'd100; WIN1 = 1'b1; WIN2 = 1'b1;
    check_pix(15, 120, 12'h000);
    check_pix(14, 150, 12'h00F);
    check_pix(10, 151, 12'h000);
    check_pix(620, 220, 12'h0F0);
    check_pix(315, 235, 12'hFFF);
    check_pix(100, 240, 12'h000);
    check_pix(314, 240, 12'h000);
    check_pix(325, 240, 12'h000);
    check_pix(625, 240, 12'h000);
    check_pix(324, 244, 12'hFFF);
    check_pix(315, 245, 12'h000);
    check_pix(624, 260, 12'h0F0);
    check_pix(620, 261, 12'h000);
    check_pix(100, 300, 12'h000);

    // Frame 2: moved ball, win latched but flash bit clear.
    wait_frame(2);
    check_pix(95, 235, 12'hFFF);
    check_pix(315, 235, 12'h000);
    check_pix(100, 300, 12'h000);

    // Frame 3: flash bit set, WIN1 wins over WIN2.
    wait_frame(3);
    check_pix(0, 0, 12'h040);
    check_pix(95, 235, 12'hFFF);
    check_pix(100, 300, 12'h040);
    check_pix(700, 300, 12'h000);

    // Mid-line reset.
    wait_pixel(400, 301);
    RESET = 1'b0;
    @(negedge CLK);
    check_val("mid_rst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'h000);
    check_val("mid_rst_hs", 32'(VGA_HS), 32'd1);
    check_val("mid_rst_vs", 32'(VGA_VS), 32'd1);
    check_val("mid_rst_fs", 32'(frame_start), 32'd0);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    #1 check_val("restart_fs1", 32'(frame_start), 32'd0);
    @(negedge CLK);
    check_val("restart_fs2", 32'(frame_start), 32'd1);
    check_pix(319, 0, 12'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
